cop_ise_mc: RTL
===============

Name: cop_ise_mc

Overview:
Multi-cycle, parametrised co-processor interface for the lightweight-crypto ISE on the rv32 core. It decodes the CUSTOM_0..3 instructions, latches operands and runs them through a configurable-latency datapath. It presents the result with a hold-until-accepted write handshake, using cop_wait for back-pressure toward the core. It is the next-generation drop-in for the single-cycle co-processor shim and uses the same cop_* port set.

Parameters:
ISE_V, 3'b111, op-group enable mask: [0] rori/xnor, [1] fsri, [2] fixed funnel shifts fsr_15/06/21/27
LATENCY, 1, cycles from accept to result; legal range 1..8
XLEN, 32, operand/result width; only 32 is legal, and any other value is an elaboration error

Ports:
cop_clk  in  1  clock
cop_rst  in  1  asynchronous active-high reset
cop_valid  in  1  instruction offered; cop_insn, cop_rs1 and cop_rs2 are valid in this cycle
cop_rdywr  in  1  core can accept the write-back this cycle
cop_ready  out  1  block can accept an instruction
cop_wait  out  1  operation in flight; core must stall
cop_wr  out  1  result valid, write-back requested
cop_insn  in  32  instruction word
cop_rs1  in  XLEN  source operand 1
cop_rs2  in  XLEN  source operand 2
cop_rd  out  XLEN  result; zero when cop_wr=0
perf_cnt  out  32  retired-op count; present only with the optional feature

Behaviour:
- Clock and reset: one clock, cop_clk. Reset is cop_rst, asynchronous and active-high.
- Decode uses funct = insn[31:25] and opcode = insn[6:0].
  - rori: CUSTOM_0, funct[6:5]=00, rotate right by funct[4:0].
  - xnor: CUSTOM_2, funct=0, computes ~(rs1^rs2).
  - fsri: CUSTOM_1, funct[6:5]=00, rd = ({rs2,rs1} >> funct[4:0])[31:0].
  - Fixed funnel shifts: CUSTOM_3, funct 0/1/2/3 gives a shift of 15/6/21/27 with the same funnel form.
  - An op is decoded only if its ISE_V group bit is set.
- Reset values: state=IDLE, cop_ready=1, cop_wait=0, cop_wr=0, cop_rd=0. The count register and the operand/funct registers clear to 0.
- State machine, IDLE / BUSY / DONE:
  - IDLE: cop_ready=1, cop_wait=0. On cop_valid with a decoded op:
    - latch the op select, imm, rs1 and rs2;
    - load cnt = LATENCY-1;
    - go to DONE if LATENCY=1, otherwise go to BUSY.
  - IDLE, cop_valid with an undecoded op: ignored. No state change and no cop_wr; cop_ready stays 1.
  - BUSY: cop_ready=0, cop_wait=1, cnt decrements each cycle. When cnt reaches 1, transition to DONE on the next edge. Total time from the accept edge to DONE entry is LATENCY edges.
  - DONE: cop_wr=1, cop_rd=result, cop_wait=1, cop_ready=0.
    - cop_rdywr=1: go to IDLE on the next edge.
    - cop_rdywr=0: hold indefinitely with result and cop_wr stable.
- Timing: cop_wr rises exactly LATENCY cycles after the accept cycle when cop_rdywr is held high. Throughput is one op per LATENCY+1 cycles. DONE never accepts a new instruction in the same cycle.
- Datapath: the result is computed from latched operands only. Changes on cop_rs1, cop_rs2 or cop_insn after accept have no effect. Rotate and shift amounts are taken mod 32; an amount of 0 returns rs1.
- Reset mid-operation (BUSY or DONE): the in-flight result is dropped, the block returns to IDLE, and all outputs take their reset values immediately (asynchronously).

Optional Feature:
COP_ISE_MC_PERF_CNT_EN
- Defined:
  - Adds a 32-bit perf_cnt register, reset to 0, that increments on every DONE cycle with cop_rdywr=1. It wraps from 0xFFFFFFFF to 0.
  - Adds a read op: CUSTOM_3 with funct=7'b1111111 returns the perf_cnt value sampled at accept (before that op's own retirement). It follows the normal LATENCY and handshake, and its retirement also counts.
- Undefined: no perf_cnt port, no counter, and funct=7'b1111111 on CUSTOM_3 is undecoded (ignored).

Test Plan:
1. LATENCY=1: rori imm=8, rs1=0x12345678, rdywr=1 -> cop_wr=1 one cycle after accept, cop_rd=0x78123456, back to IDLE and cop_ready=1 next cycle.
2. LATENCY=4: xnor rs1=0xF0F0F0F0, rs2=0x0F0F00FF -> cop_wait=1 for 3 BUSY cycles, then cop_wr=1 with cop_rd=0x00000FF0 4 cycles after accept. The operand bus is scrambled after accept and the result is unchanged.
3. fsri imm=4, rs1=0x12345678, rs2=0x9ABCDEF0 -> 0x01234567. fsr_15 with rs1=0, rs2=0xFFFFFFFF -> 0xFFFE0000.
4. Stall: result in DONE, cop_rdywr=0 for 3 cycles -> cop_wr and cop_rd held stable and cop_ready=0. The cycle after rdywr=1 -> IDLE.
5. ISE_V=3'b001: fsri or fsr_15 offered -> ignored, with cop_wr=0 and cop_ready=1 throughout. An undecoded CUSTOM_2 with funct=1 is likewise ignored.
6. Reset asserted mid-BUSY (LATENCY=8, cycle 3) -> outputs return to reset values immediately and no cop_wr ever appears. With PERF_CNT_EN, 3 retired ops followed by the read op -> cop_rd=3, and perf_cnt=4 afterwards.

Source files
------------

// File: rtl/cop_ise_mc.sv
// cop_ise_mc: multi-cycle lightweight-crypto ISE co-processor (optional perf counter: COP_ISE_MC_PERF_CNT_EN)
module cop_ise_mc #(
  parameter logic [2:0] ISE_V   = 3'b111,
  parameter int         LATENCY = 1,
  parameter int         XLEN    = 32
) (
  input  logic            cop_clk,
  input  logic            cop_rst,
  input  logic            cop_valid,
  input  logic            cop_rdywr,
  output logic            cop_ready,
  output logic            cop_wait,
  output logic            cop_wr,
  input  logic [31:0]     cop_insn,
  input  logic [XLEN-1:0] cop_rs1,
  input  logic [XLEN-1:0] cop_rs2,
  output logic [XLEN-1:0] cop_rd
`ifdef COP_ISE_MC_PERF_CNT_EN
  ,
  output logic [31:0]     perf_cnt
`endif
);
  if (XLEN != 32) begin : g_xlen_chk
    $error("cop_ise_mc: XLEN must be 32");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_lat_chk
    $error("cop_ise_mc: LATENCY must be 1..8");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      st;
  logic [2:0]  cnt;
  logic        x_sel;
  logic [4:0]  sh;
  logic [31:0] a, b;
  logic [6:0]  funct, opc;
  logic        is_ror, is_xnor, is_fsri, is_fix, is_rd, dec;
  logic [4:0]  fix_sh, d_sh;
  logic [31:0] cnt_now, d_a, d_b, res;
  logic [63:0] fun;
  assign funct = cop_insn[31:25];
  assign opc   = cop_insn[6:0];
`ifdef COP_ISE_MC_PERF_CNT_EN
  assign cnt_now = perf_cnt;
  assign is_rd   = opc == 7'h7B && funct == 7'h7F;
`else
  assign cnt_now = '0;
  assign is_rd   = 1'b0;
`endif
  // Decode the offered instruction; rori is a funnel of rs1 with itself and the
  // perf read is a zero-amount funnel of the sampled count.
  always_comb begin
    is_ror  = ISE_V[0] && opc == 7'h0B && funct[6:5] == 2'b00;
    is_xnor = ISE_V[0] && opc == 7'h5B && funct == 7'h00;
    is_fsri = ISE_V[1] && opc == 7'h2B && funct[6:5] == 2'b00;
    is_fix  = ISE_V[2] && opc == 7'h7B && funct[6:2] == 5'b00000;
    dec     = is_ror || is_xnor || is_fsri || is_fix || is_rd;
    fix_sh  = funct[1:0] == 2'd0 ? 5'd15 : funct[1:0] == 2'd1 ? 5'd6 :
              funct[1:0] == 2'd2 ? 5'd21 : 5'd27;
    d_sh    = is_fix ? fix_sh : is_rd ? 5'd0 : funct[4:0];
    d_a     = is_rd ? cnt_now : cop_rs1;
    d_b     = (is_ror || is_rd) ? d_a : cop_rs2;
  end
  assign fun    = {b, a} >> sh;
  assign res    = x_sel ? ~(a ^ b) : fun[31:0];
  assign cop_rd = cop_wr ? res : '0;
  // Control FSM: accept in IDLE, count down in BUSY, hold the result in DONE until taken.
  always_ff @(posedge cop_clk or posedge cop_rst) begin
    if (cop_rst) begin
      st        <= IDLE;
      cop_ready <= 1'b1;
      cop_wait  <= 1'b0;
      cop_wr    <= 1'b0;
      cnt       <= '0;
      x_sel     <= 1'b0;
      sh        <= '0;
      a         <= '0;
      b         <= '0;
    end else begin
      case (st)
        IDLE: if (cop_valid && dec) begin
          x_sel     <= is_xnor;
          sh        <= d_sh;
          a         <= d_a;
          b         <= d_b;
          cnt       <= 3'(LATENCY - 1);
          st        <= LATENCY == 1 ? DONE : BUSY;
          cop_wr    <= LATENCY == 1;
          cop_ready <= 1'b0;
          cop_wait  <= 1'b1;
        end
        BUSY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            st     <= DONE;
            cop_wr <= 1'b1;
          end
        end
        DONE: if (cop_rdywr) begin
          st        <= IDLE;
          cop_wr    <= 1'b0;
          cop_ready <= 1'b1;
          cop_wait  <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
`ifdef COP_ISE_MC_PERF_CNT_EN
  // Count every retirement (DONE with the write-back taken), wrapping naturally.
  always_ff @(posedge cop_clk or posedge cop_rst) begin
    if (cop_rst) perf_cnt <= '0;
    else if (st == DONE && cop_rdywr) perf_cnt <= perf_cnt + 32'd1;
  end
`endif
endmodule
